// File: rtl/ca_pkg.sv
// ---------------------------------------------------------------------------
// ca_pkg
// Shared definitions for the cellular-automaton pattern generator:
//   - ca_state_e : controller states (IDLE, EMIT, STEP, DONE)
//   - caBytes()  : number of output bytes in a cell row of a given width
// ---------------------------------------------------------------------------
package ca_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } ca_state_e;

    // Row width is always a whole number of bytes, so this divides exactly.
    function automatic int caBytes(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/ca_next_row.sv
// ---------------------------------------------------------------------------
// ca_next_row
// Purely combinational one-generation step of an elementary (Wolfram) cellular
// automaton.
// Ports:
//   row  [WIDTH-1:0] : current generation
//   rule [7:0]       : Wolfram rule number (bit n gives the new cell for
//                      neighbourhood {L,C,R} == n)
//   wrap             : 1 = toroidal boundary, 0 = boundary cells read as 0
//   next [WIDTH-1:0] : following generation
// ---------------------------------------------------------------------------
module ca_next_row #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] row,
    input  logic [7:0]       rule,
    input  logic             wrap,
    output logic [WIDTH-1:0] next
);

    // Row padded by one boundary cell on each side, so ext[i+2:i] is the
    // {L,C,R} neighbourhood of cell i. The MSB pad is the left neighbour of
    // the top cell; it wraps around to cell 0 (and vice versa at the bottom).
    logic [WIDTH+1:0] ext;

    assign ext = {wrap & row[0], row, wrap & row[WIDTH-1]};

    always_comb begin
        next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            next[i] = rule[ext[i +: 3]];
        end
    end

endmodule

// File: rtl/ca_pattern_gen.sv
// ---------------------------------------------------------------------------
// ca_pattern_gen
// Generates successive rows of an elementary cellular automaton and streams
// each row out byte-serially (least-significant byte first) over a
// valid/ready interface.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start, stop     : begin a run (IDLE only) / abort the current run
//   rule, wrap      : Wolfram rule and boundary mode, latched at start
//   seed_sel,seed_in: row-0 source (1 = seed_in, 0 = single centre cell)
//   n_rows          : rows to emit including row 0 (0 = until stop)
//   out_data/valid/ready/last : byte stream of the current row
//   busy, done      : run in progress / one-cycle completion pulse
//   gen_count       : index of the row being emitted
// ---------------------------------------------------------------------------
module ca_pattern_gen
    import ca_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [7:0]       rule,
    input  logic             wrap,
    input  logic             seed_sel,
    input  logic [WIDTH-1:0] seed_in,
    input  logic [15:0]      n_rows,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic [15:0]      gen_count
);

    localparam int BYTES = caBytes(WIDTH);
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
    localparam logic [WIDTH-1:0] CENTER_SEED = {{(WIDTH-1){1'b0}}, 1'b1} << (WIDTH / 2);

    ca_state_e        state_q, state_d;
    logic [WIDTH-1:0] row_q, row_d;
    logic [7:0]       rule_q, rule_d;
    logic             wrap_q, wrap_d;
    logic [15:0]      nRows_q, nRows_d;
    logic [15:0]      gen_q, gen_d;
    logic [IDX_W-1:0] byteIdx_q, byteIdx_d;

    logic [WIDTH-1:0]           nextRow;
    logic [BYTES-1:0][7:0]      rowBytes;

    ca_next_row #(
        .WIDTH (WIDTH)
    ) u_next_row (
        .row  (row_q),
        .rule (rule_q),
        .wrap (wrap_q),
        .next (nextRow)
    );

    assign rowBytes = row_q;

    // State register; reset clears everything so all outputs read as zero
    // as soon as rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            rule_q    <= '0;
            wrap_q    <= 1'b0;
            nRows_q   <= '0;
            gen_q     <= '0;
            byteIdx_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            rule_q    <= rule_d;
            wrap_q    <= wrap_d;
            nRows_q   <= nRows_d;
            gen_q     <= gen_d;
            byteIdx_q <= byteIdx_d;
        end
    end

    // Next-state logic. stop is checked before byte acceptance so an abort
    // never lets one more byte count as consumed. gen_count is a plain
    // 16-bit counter, so free-running runs wrap naturally.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        rule_d    = rule_q;
        wrap_d    = wrap_q;
        nRows_d   = nRows_q;
        gen_d     = gen_q;
        byteIdx_d = byteIdx_q;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    row_d     = seed_sel ? seed_in : CENTER_SEED;
                    rule_d    = rule;
                    wrap_d    = wrap;
                    nRows_d   = n_rows;
                    gen_d     = '0;
                    byteIdx_d = '0;
                    state_d   = EMIT;
                end
            end
            EMIT: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    if (byteIdx_q == LAST_IDX) begin
                        byteIdx_d = '0;
                        if ((nRows_q != 16'd0) && ((gen_q + 16'd1) == nRows_q)) begin
                            state_d = DONE;
                        end else begin
                            state_d = STEP;
                        end
                    end else begin
                        byteIdx_d = byteIdx_q + IDX_W'(1);
                    end
                end
            end
            STEP: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    row_d   = nextRow;
                    gen_d   = gen_q + 16'd1;
                    state_d = EMIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state only, so they are stable
    // throughout a stalled byte.
    always_comb begin
        out_valid = (state_q == EMIT);
        out_last  = (state_q == EMIT) && (byteIdx_q == LAST_IDX);
        out_data  = (state_q == EMIT) ? rowBytes[byteIdx_q] : 8'h00;
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        gen_count = gen_q;
    end

endmodule

// File: doc/ca_pattern_gen.md
CA_PATTERN_GEN -- requirements
Module: ca_pattern_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the cell-row width in bits; legal values are multiples of 8, from 8 to 64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: begins a run; honoured only in IDLE.
REQ-005 SHALL have port stop, input, 1 bit: aborts the run in progress.
REQ-006 SHALL have port rule, input, 8 bits: Wolfram rule number, latched at start.
REQ-007 SHALL have port wrap, input, 1 bit: 1 selects toroidal boundary, 0 selects zero boundary; latched at start.
REQ-008 SHALL have port seed_sel, input, 1 bit: 1 selects seed_in as row 0, 0 selects a single set cell at bit WIDTH/2; latched at start.
REQ-009 SHALL have port seed_in, input, WIDTH bits: custom row-0 pattern.
REQ-010 SHALL have port n_rows, input, 16 bits: number of rows to emit including row 0; 0 means run until stop; latched at start.
REQ-011 SHALL have port out_data, output, 8 bits: one byte of the current row.
REQ-012 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer accepts the byte.
REQ-014 SHALL have port out_last, output, 1 bit: out_data is the final byte of a row.
REQ-015 SHALL have port busy, output, 1 bit: high in any state except IDLE.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse at normal completion.
REQ-017 SHALL have port gen_count, output, 16 bits: index of the row currently being emitted.

Function
REQ-018 SHALL implement FSM states IDLE, EMIT, STEP and DONE.
REQ-019 On start in IDLE, SHALL on the same edge load row 0, latch rule/wrap/n_rows, clear gen_count and the byte index, and enter EMIT.
REQ-020 In EMIT, SHALL present the row byte-serially, least-significant byte first, with out_valid high; out_last SHALL be high on byte WIDTH/8-1.
REQ-021 While out_valid is high and out_ready is low, SHALL hold out_data, out_last and out_valid stable.
REQ-022 Each cycle with out_valid and out_ready both high SHALL count as one accepted byte; accepting the last byte of a row SHALL leave EMIT.
REQ-023 After the last byte, SHALL enter DONE if n_rows is nonzero and gen_count+1 equals n_rows; otherwise SHALL enter STEP.
REQ-024 In STEP (exactly one cycle, out_valid low), SHALL set new[i] = rule[{L,C,R}] with L=row[i+1], C=row[i], R=row[i-1], then increment gen_count and return to EMIT.
REQ-025 Out-of-range neighbours SHALL read 0 when wrap=0 and SHALL read the opposite-end cell when wrap=1.
REQ-026 gen_count SHALL wrap from 0xFFFF to 0 when n_rows is 0.
REQ-027 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-028 stop in any non-IDLE state SHALL move to IDLE on the next edge, with out_valid low and no done pulse; stop SHALL take priority over a same-cycle byte acceptance.
REQ-029 start while busy SHALL be ignored; start and stop together in IDLE SHALL leave the block in IDLE.

Reset
REQ-030 rst SHALL immediately force IDLE, row=0, gen_count=0, byte index 0, out_valid=0, out_last=0, out_data=0x00, done=0 and busy=0, including in the middle of a run.

Structure
REQ-031 Package ca_pkg SHALL hold the state enum and constant BYTES=WIDTH/8 (as a function of WIDTH).
REQ-032 The next-row logic SHALL be a combinational sub-module ca_next_row, parameterised by WIDTH, with inputs row, rule and wrap and output next.

Verification
REQ-033 WIDTH=16, rule=90, seed_sel=0, wrap=0, n_rows=4, out_ready=1 -> rows 0x0100, 0x0280, 0x0440, 0x0AA0; bytes 00,01,80,02,40,04,A0,0A; out_last on every second byte; single done pulse.
REQ-034 Backpressure: out_ready low for 5 cycles mid-row -> out_data and out_valid held; the byte stream is identical to the REQ-033 stream.
REQ-035 rule=90, seed_sel=1, seed_in=0x0001 -> row 1 equals 0x8002 with wrap=1 and 0x0002 with wrap=0.
REQ-036 rule=204 (identity), n_rows=0, seed_in=0xA5C3 -> every row 0xA5C3; gen_count increments; stop at row 10 -> IDLE next cycle with no done pulse.
REQ-037 rst asserted mid-EMIT -> outputs at reset values before the next clock edge; a fresh start reproduces row 0 exactly.
REQ-038 start pulsed while busy -> no effect on the stream or on gen_count.
